approx_mul_pipe: RTL and testbench
==================================

APPROX_MUL_PIPE -- requirements
Module: approx_mul_pipe

Interface
REQ-001 SHALL have parameter N, default 8, operand width (3..32).
REQ-002 SHALL have parameter K, default 2, number of low multiplier rows approximated (1 <= K < N).
REQ-003 SHALL have parameter T, default 6, lowest column kept from approximated rows (K <= T <= N+K-2).
REQ-004 SHALL have clk, input, 1, single clock, all state on rising edge.
REQ-005 SHALL have rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have in_valid, input, 1, operand pair present.
REQ-007 SHALL have in_ready, output, 1, block accepts operands this cycle.
REQ-008 SHALL have x, input, N, unsigned multiplier.
REQ-009 SHALL have y, input, N, unsigned multiplicand.
REQ-010 SHALL have out_valid, output, 1, product present.
REQ-011 SHALL have out_ready, input, 1, consumer takes product this cycle.
REQ-012 SHALL have z, output, 2N, approximate unsigned product.

Function
REQ-013 SHALL define partial-product bit p_r[j] = x[r] & y[j], weight r+j.
REQ-014 SHALL form high product H = y * x[N-1:K], exact, shifted left K.
REQ-015 SHALL form compressed vector C: bit c = OR of p_r[c-r] over r<K with 0 <= c-r < N, for T <= c <= N+K-2; bits below T zero.
REQ-016 SHALL output z = (H << K) + C, computed at full 2N width, no overflow possible.
REQ-017 SHALL have two pipeline stages: S1 registers H and C; S2 registers the final sum into z.
REQ-018 SHALL accept operands on a cycle with in_valid & in_ready; unstalled latency is exactly 2 cycles to out_valid.
REQ-019 SHALL sustain one result per cycle when out_ready stays high.
REQ-020 SHALL transfer a result on out_valid & out_ready; without out_ready, z and out_valid hold stable.
REQ-021 SHALL advance each stage when empty or when its successor advances; in_ready = !S1_valid | S1 advances (no combinational path from in_valid to in_ready).
REQ-022 SHALL, under stall, hold at most two accepted items and deassert in_ready once both stages are full.
REQ-023 SHALL ignore x and y when in_valid is low or in_ready is low.

Reset
REQ-024 SHALL, while rst_n low, force out_valid=0, z=0, stage valids=0, in_ready=0, asynchronously.
REQ-025 SHALL discard in-flight items on reset mid-operation; in_ready rises on first clk after rst_n deasserts.

Configuration
REQ-026 SHALL, with macro AMUL_EXACT_MODE_EN defined, add input port exact (1 bit) sampled with operands; exact=1 gives z = x*y exactly for that item, carried through the pipeline.
REQ-027 SHALL, without AMUL_EXACT_MODE_EN, omit the exact port; every item uses REQ-016.

Structure
REQ-028 SHALL place defaults for N, K, T and a width-check function in shared package amul_pkg.
REQ-029 SHALL implement C in sub-module amul_lowrow_compress (combinational, parameters N, K, T).

Verification (N=8, K=2, T=6)
REQ-030 SHALL check x=0xFF, y=0xFF -> z=64708 (H<<2=64260, C=448) two cycles later.
REQ-031 SHALL check x=0x03, y=0xFF -> z=448; x=0x04, y=0x05 -> z=20.
REQ-032 SHALL check, with AMUL_EXACT_MODE_EN, x=0xFF, y=0xFF, exact=1 -> z=65025.
REQ-033 SHALL check back-to-back 8 items with out_ready=1 -> 8 results on consecutive cycles, in order.
REQ-034 SHALL check out_ready=0, 3 items offered -> 2 accepted, in_ready low, z stable; out_ready=1 -> results drain in order, third accepted.
REQ-035 SHALL check rst_n low while out_valid=1 -> out_valid=0, z=0 without waiting for clk.

Source files
------------

// File: rtl/amul_pkg.sv
// Shared defaults and parameter legality check for the approximate multiplier pipeline.
package amul_pkg;

  localparam int AMUL_N_DEF = 8;
  localparam int AMUL_K_DEF = 2;
  localparam int AMUL_T_DEF = 6;

  function automatic bit amul_params_ok(input int n, input int k, input int t);
    return (n >= 3) && (n <= 32) && (k >= 1) && (k < n) && (t >= k) && (t <= n + k - 2);
  endfunction

endpackage

// File: rtl/amul_lowrow_compress.sv
// Combinational OR-compression of the K low multiplier rows; columns below T are dropped.
module amul_lowrow_compress
  import amul_pkg::*;
#(
  parameter int N = AMUL_N_DEF,
  parameter int K = AMUL_K_DEF,
  parameter int T = AMUL_T_DEF
) (
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  output logic [2*N-1:0] c
);

  for (genvar col = 0; col < 2 * N; col++) begin : g_col
    if (col >= T && col <= N + K - 2) begin : g_keep
      logic [K-1:0] terms;
      for (genvar r = 0; r < K; r++) begin : g_row
        // col >= T >= K > r, so col - r never goes negative
        if (col - r < N) begin : g_in
          assign terms[r] = x[r] & y[col-r];
        end else begin : g_out
          assign terms[r] = 1'b0;
        end
      end
      assign c[col] = |terms;
    end else begin : g_zero
      assign c[col] = 1'b0;
    end
  end

endmodule

// File: rtl/approx_mul_pipe.sv
// Two-stage valid/ready approximate unsigned multiplier (exact high rows, OR-compressed low rows).
// Optional per-item exact product via macro AMUL_EXACT_MODE_EN.
module approx_mul_pipe
  import amul_pkg::*;
#(
  parameter int N = AMUL_N_DEF,
  parameter int K = AMUL_K_DEF,
  parameter int T = AMUL_T_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
`ifdef AMUL_EXACT_MODE_EN
  input  logic           exact,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] z
);

  localparam int W = 2 * N;

  if (!amul_params_ok(N, K, T)) begin : g_bad_params
    $error("approx_mul_pipe: illegal N/K/T combination");
  end

  logic [W-1:0] h_approx;
  logic [W-1:0] c_vec;
  logic [W-1:0] h_next;
  logic [W-1:0] c_next;

  assign h_approx = ({{N{1'b0}}, y} * {{(N+K){1'b0}}, x[N-1:K]}) << K;

  amul_lowrow_compress #(
    .N(N),
    .K(K),
    .T(T)
  ) u_compress (
    .x(x),
    .y(y),
    .c(c_vec)
  );

`ifdef AMUL_EXACT_MODE_EN
  logic [W-1:0] h_exact;
  assign h_exact = {{N{1'b0}}, x} * {{N{1'b0}}, y};
  // exact items ride the same S1 slot: full product in H, compressed term zeroed
  assign h_next  = exact ? h_exact : h_approx;
  assign c_next  = exact ? '0 : c_vec;
`else
  assign h_next  = h_approx;
  assign c_next  = c_vec;
`endif

  logic         ready_en_q;
  logic         s1_valid;
  logic [W-1:0] s1_h;
  logic [W-1:0] s1_c;
  logic         s2_ready;

  assign s2_ready = !out_valid || out_ready;
  // ready_en_q holds in_ready low during reset and until the first clock afterwards
  assign in_ready = ready_en_q && (!s1_valid || s2_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
      s1_valid   <= 1'b0;
      s1_h       <= '0;
      s1_c       <= '0;
      out_valid  <= 1'b0;
      z          <= '0;
    end else begin
      ready_en_q <= 1'b1;
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_h <= h_next;
          s1_c <= c_next;
        end
      end
      if (s2_ready) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          z <= s1_h + s1_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Directed bench for approx_mul_pipe at N=8, K=2, T=6; exact-mode vectors when AMUL_EXACT_MODE_EN is set.
module tb_approx_mul_pipe;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [N-1:0]   x = '0;
  logic [N-1:0]   y = '0;
  logic           in_ready;
  logic           out_valid;
  logic [2*N-1:0] z;
`ifdef AMUL_EXACT_MODE_EN
  logic           exact = 1'b0;
`endif

  approx_mul_pipe #(.N(8), .K(2), .T(6)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .x(x),
    .y(y),
`ifdef AMUL_EXACT_MODE_EN
    .exact(exact),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .z(z)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    bit          ex;
    logic [15:0] z;
  } vec_t;

  vec_t vecs[$];
  int   d0;
  int   idx;

  task automatic drive(input logic [7:0] xv, input logic [7:0] yv, input bit ev);
    x = xv;
    y = yv;
    in_valid = 1'b1;
`ifdef AMUL_EXACT_MODE_EN
    exact = ev;
`else
    if (ev) $display("exact flag ignored in this build");
`endif
  endtask

  initial begin
    vecs.push_back('{8'hFF, 8'hFF, 1'b0, 16'd64708});
    vecs.push_back('{8'h03, 8'hFF, 1'b0, 16'd448});
    vecs.push_back('{8'h04, 8'h05, 1'b0, 16'd20});
    vecs.push_back('{8'h00, 8'hFF, 1'b0, 16'd0});
    vecs.push_back('{8'hFF, 8'h00, 1'b0, 16'd0});
    vecs.push_back('{8'h01, 8'h40, 1'b0, 16'd64});
    vecs.push_back('{8'h02, 8'h80, 1'b0, 16'd256});
    vecs.push_back('{8'h81, 8'h03, 1'b0, 16'd384});
    vecs.push_back('{8'h10, 8'h10, 1'b0, 16'd256});
    vecs.push_back('{8'hAA, 8'h55, 1'b0, 16'd14408});
    vecs.push_back('{8'h55, 8'hAA, 1'b0, 16'd14408});
    vecs.push_back('{8'h07, 8'h60, 1'b0, 16'd576});
`ifdef AMUL_EXACT_MODE_EN
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 16'd65025});
    vecs.push_back('{8'h81, 8'h03, 1'b1, 16'd387});
    vecs.push_back('{8'h07, 8'h60, 1'b1, 16'd672});
`endif

    // reset values while rst_n is low
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_z", 64'(z), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_before_clk", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("in_ready_after_clk", 64'(in_ready), 64'd1);

    // back-to-back stream, out_ready high: 2-cycle latency, one result per cycle, in order
    out_ready = 1'b1;
    d0  = cyc;
    idx = 0;
    fork
      begin
        for (int i = 0; i < vecs.size(); i++) begin
          if (i > 0) @(negedge clk);
          drive(vecs[i].x, vecs[i].y, vecs[i].ex);
          #1;
          check($sformatf("stream_in_ready_%0d", i), 64'(in_ready), 64'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 200 && idx < vecs.size(); k++) begin
          @(negedge clk);
          if (out_valid) begin
            check($sformatf("stream_z_%0d", idx), 64'(z), 64'(vecs[idx].z));
            check($sformatf("stream_cycle_%0d", idx), 64'(cyc), 64'(d0 + 2 + idx));
            idx++;
          end
        end
        if (idx < vecs.size()) check("stream_timeout", 64'(idx), 64'(vecs.size()));
      end
    join
`ifdef AMUL_EXACT_MODE_EN
    exact = 1'b0;
`endif

    // stall: three items offered with out_ready low, only two fit
    @(negedge clk);
    out_ready = 1'b0;
    drive(8'hFF, 8'hFF, 1'b0);
    #1 check("stall_rdy_a", 64'(in_ready), 64'd1);
    @(negedge clk);
    drive(8'h04, 8'h05, 1'b0);
    #1 check("stall_rdy_b", 64'(in_ready), 64'd1);
    @(negedge clk);
    drive(8'h03, 8'hFF, 1'b0);
    #1 check("stall_rdy_c", 64'(in_ready), 64'd0);
    check("stall_valid", 64'(out_valid), 64'd1);
    check("stall_z", 64'(z), 64'd64708);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("stall_hold_z_%0d", k), 64'(z), 64'd64708);
      check($sformatf("stall_hold_valid_%0d", k), 64'(out_valid), 64'd1);
      check($sformatf("stall_hold_rdy_%0d", k), 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 check("drain_rdy_c", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("drain_z_b", 64'(z), 64'd20);
    check("drain_valid_b", 64'(out_valid), 64'd1);
    @(negedge clk);
    check("drain_z_c", 64'(z), 64'd448);
    check("drain_valid_c", 64'(out_valid), 64'd1);
    @(negedge clk);
    check("drain_empty", 64'(out_valid), 64'd0);

    // asynchronous reset while a result is held
    out_ready = 1'b0;
    drive(8'h10, 8'h10, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("prerst_valid", 64'(out_valid), 64'd1);
    check("prerst_z", 64'(z), 64'd256);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_z", 64'(z), 64'd0);
    check("async_rst_rdy", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rerst_rdy_before_clk", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("rerst_rdy", 64'(in_ready), 64'd1);
    check("rerst_flushed", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    drive(8'h04, 8'h05, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check("post_rst_early", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_z", 64'(z), 64'd20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
